// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush controller for the 5-stage core.
// Handles load-use bubbles, cache waits, taken branches and halt, plus a stall-cycle counter.
module hazard_unit #(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 16,
    parameter int LOAD_FWD_MEM = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_mem,
    input  logic             dmemWEN_mem,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] wsel_ex,
    input  logic [REG_W-1:0] id_rsel1,
    input  logic [REG_W-1:0] id_rsel2,
    input  logic             id_uses_rt,
    input  logic             hu_override_ex,
    input  logic             branch_taken_ex,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN, LU2, HALTED} state_t;

    state_t state, next;
    logic   freeze, lu;

    assign freeze = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    assign lu = memread_ex & (wsel_ex != '0) & ~hu_override_ex &
                ((id_rsel1 == wsel_ex) | (id_uses_rt & (id_rsel2 == wsel_ex)));
    assign exmem_flush = 1'b0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next;
    end

    always_comb begin
        next       = state;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!nRST || halt_wb || state == HALTED || freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            next = !nRST ? RUN : (halt_wb || state == HALTED) ? HALTED : state;
        end else if (state == RUN && branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state == LU2 || lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            next       = (state == RUN && LOAD_FWD_MEM == 0) ? LU2 : RUN;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // halt cycles are not stalls: the counter freezes once HALT reaches WB
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            stall_count <= '0;
        else if (state != HALTED && !halt_wb && !pc_en && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: table-driven scoreboard bench for hazard_unit.
// A second instance (2-bit counter, MEM-stage load forwarding) covers one-bubble load-use and saturation.
module tb_hazard_unit;
    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit = 1'b0, dhit = 1'b0, dmemREN_mem = 1'b0, dmemWEN_mem = 1'b0, memread_ex = 1'b0;
    logic [4:0] wsel_ex = '0, id_rsel1 = '0, id_rsel2 = '0;
    logic       id_uses_rt = 1'b0, hu_override_ex = 1'b0, branch_taken_ex = 1'b0, halt_wb = 1'b0;
    logic       pc_en0, ifid_en0, idex_en0, exmem_en0, memwb_en0, ifid_fl0, idex_fl0, exmem_fl0;
    logic       pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_fl1, idex_fl1, exmem_fl1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 CLK = ~CLK;

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN_mem(dmemREN_mem),
        .dmemWEN_mem(dmemWEN_mem), .memread_ex(memread_ex), .wsel_ex(wsel_ex),
        .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_uses_rt(id_uses_rt),
        .hu_override_ex(hu_override_ex), .branch_taken_ex(branch_taken_ex), .halt_wb(halt_wb),
        .pc_en(pc_en0), .ifid_en(ifid_en0), .idex_en(idex_en0), .exmem_en(exmem_en0),
        .memwb_en(memwb_en0), .ifid_flush(ifid_fl0), .idex_flush(idex_fl0),
        .exmem_flush(exmem_fl0), .stall_count(cnt0)
    );

    hazard_unit #(.CNT_W(2), .LOAD_FWD_MEM(1)) dut_s (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN_mem(dmemREN_mem),
        .dmemWEN_mem(dmemWEN_mem), .memread_ex(memread_ex), .wsel_ex(wsel_ex),
        .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_uses_rt(id_uses_rt),
        .hu_override_ex(hu_override_ex), .branch_taken_ex(branch_taken_ex), .halt_wb(halt_wb),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .idex_en(idex_en1), .exmem_en(exmem_en1),
        .memwb_en(memwb_en1), .ifid_flush(ifid_fl1), .idex_flush(idex_fl1),
        .exmem_flush(exmem_fl1), .stall_count(cnt1)
    );

    // {pc, ifid, idex, exmem, memwb enables, ifid/idex/exmem flushes}
    localparam logic [7:0] ALL  = 8'b11111_000;
    localparam logic [7:0] NONE = 8'b00000_000;
    localparam logic [7:0] LU   = 8'b00111_010;
    localparam logic [7:0] BR   = 8'b11111_110;
    localparam logic [7:0] MISS = 8'b01111_100;

    typedef struct {
        logic       rn, ih, dh, ren, wen, mr;
        logic [4:0] ws, r1, r2;
        logic       urt, ov, br, hl, sel;
        logic [7:0] eo;
        int         ec;
        int         id;
    } vec_t;

    vec_t vs[$];
    vec_t sb[$];
    int   n_checks = 0, n_fail = 0;

    function automatic vec_t mk(input logic rn, ih, dh, ren, wen, mr, input logic [4:0] ws, r1, r2,
                                input logic urt, ov, br, hl, sel, input logic [7:0] eo, input int ec);
        vec_t v;
        v = '{rn:rn, ih:ih, dh:dh, ren:ren, wen:wen, mr:mr, ws:ws, r1:r1, r2:r2,
              urt:urt, ov:ov, br:br, hl:hl, sel:sel, eo:eo, ec:ec, id:0};
        return v;
    endfunction

    task automatic step(input vec_t v, input int id);
        vec_t r;
        logic [7:0] got_o;
        int got_c;
        @(posedge CLK);
        #1;
        {nRST, ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex} = {v.rn, v.ih, v.dh, v.ren, v.wen, v.mr};
        {wsel_ex, id_rsel1, id_rsel2} = {v.ws, v.r1, v.r2};
        {id_uses_rt, hu_override_ex, branch_taken_ex, halt_wb} = {v.urt, v.ov, v.br, v.hl};
        v.id = id;
        sb.push_back(v);
        @(negedge CLK);
        r = sb.pop_front();
        got_o = r.sel ? {pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_fl1, idex_fl1, exmem_fl1}
                      : {pc_en0, ifid_en0, idex_en0, exmem_en0, memwb_en0, ifid_fl0, idex_fl0, exmem_fl0};
        got_c = r.sel ? int'(cnt1) : int'(cnt0);
        n_checks++;
        if (got_o !== r.eo) begin
            n_fail++;
            $display("FAIL vec%0d outputs got %b want %b", r.id, got_o, r.eo);
        end
        n_checks++;
        if (got_c != r.ec) begin
            n_fail++;
            $display("FAIL vec%0d stall_count got %0d want %0d", r.id, got_c, r.ec);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //              rn ih dh rn wn mr ws r1 r2 ur ov br hl sl  out  cnt
        vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL,  0));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, LU,   0));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, LU,   1));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, ALL,  2));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 3, 0, 3, 1, 0, 0, 0, 0, LU,   2));
        vs.push_back(mk(1, 1, 0, 1, 0, 1, 3, 0, 3, 1, 0, 0, 0, 0, NONE, 3));
        vs.push_back(mk(1, 1, 0, 1, 0, 1, 3, 0, 3, 1, 0, 0, 0, 0, NONE, 4));
        vs.push_back(mk(1, 1, 0, 1, 0, 1, 3, 0, 3, 1, 0, 0, 0, 0, NONE, 5));
        vs.push_back(mk(1, 1, 1, 1, 0, 1, 3, 0, 3, 1, 0, 0, 0, 0, LU,   6));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL,  7));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2, 0, 0, 1, 0, 0, 0, ALL,  7));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 4, 1, 4, 0, 0, 0, 0, 0, ALL,  7));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, ALL,  7));
        vs.push_back(mk(1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 0, 0, BR,   7));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL,  7));
        vs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MISS, 7));
        vs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MISS, 8));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL,  9));
        vs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, LU,   9));
        vs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 1, 0, 0, LU,  10));
        vs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE,11));
        vs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 12));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, LU,  12));
        vs.push_back(mk(0, 1, 0, 1, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, NONE, 0));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL,  0));
        vs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE, 0));
        vs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 1));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 1));
        vs.push_back(mk(1, 0, 0, 1, 0, 1, 2, 2, 0, 0, 0, 1, 0, 0, NONE, 1));
        vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL,  0));
        // second instance: a single bubble on load-use
        vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0));
        vs.push_back(mk(1, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 1, LU,   0));
        vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ALL,  1));
        foreach (vs[i]) step(vs[i], i);
        // 2-bit counter saturates at 3 during consecutive fetch misses, then freezes on halt
        for (int k = 0; k < 5; k++)
            step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MISS, (k + 1 > 3) ? 3 : k + 1), 100 + k);
        step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 3), 105);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 3), 106);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 3), 107);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
